// File: rtl/axis_delay_line_pkg.sv
// Shared helpers for the AXI-Stream delay line.
// Sizes the occupancy counter so a zero-depth build still has a 1-bit port.
package axis_delay_line_pkg;

  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_delay_stage.sv
// One register stage of the delay line: valid bit plus payload.
// Loads whenever empty or when the stage ahead can take its current beat.
module axis_delay_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  next_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  ready
);

  assign ready = ~out_valid | next_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ready) begin
      out_valid <= in_valid;
      // Payload only moves with a real beat, so an idle slot keeps its old data.
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/axis_delay_line.sv
// AXI-Stream register delay line of DEPTH stages with bubble collapsing and flush.
// DEPTH=0 degenerates to a wire; occupancy is a registered count of valid stages.
module axis_delay_line
  import axis_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;

      assign m_axis_tvalid = s_axis_tvalid;
      assign m_axis_tdata  = s_axis_tdata;
      assign m_axis_tlast  = s_axis_tlast;
      assign s_axis_tready = m_axis_tready;
      assign occupancy     = '0;
      assign unused_bypass = &{1'b0, clk, reset, flush};
    end else begin : g_pipe
      logic [DEPTH-1:0] nxt_vld_vec;
      logic [OCC_W-1:0] nxt_occ;

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                  in_vld;
        logic [DATA_WIDTH-1:0] in_dat;
        logic                  in_lst;
        logic                  nxt_rdy;
        logic                  vld;
        logic [DATA_WIDTH-1:0] dat;
        logic                  lst;
        logic                  rdy;

        if (i == 0) begin : g_head
          assign in_vld = s_axis_tvalid;
          assign in_dat = s_axis_tdata;
          assign in_lst = s_axis_tlast;
        end else begin : g_body
          assign in_vld = g_stage[i-1].vld;
          assign in_dat = g_stage[i-1].dat;
          assign in_lst = g_stage[i-1].lst;
        end

        if (i == DEPTH - 1) begin : g_tail
          assign nxt_rdy = m_axis_tready;
        end else begin : g_mid
          assign nxt_rdy = g_stage[i+1].rdy;
        end

        axis_delay_stage #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
          .clk        (clk),
          .reset      (reset),
          .flush      (flush),
          .in_valid   (in_vld),
          .in_data    (in_dat),
          .in_last    (in_lst),
          .next_ready (nxt_rdy),
          .out_valid  (vld),
          .out_data   (dat),
          .out_last   (lst),
          .ready      (rdy)
        );

        // Mirrors the stage's own load rule so the count lands on the same edge.
        assign nxt_vld_vec[i] = rdy ? in_vld : vld;
      end

      // Reset and flush both block acceptance even though stage 0 looks ready.
      assign s_axis_tready = g_stage[0].rdy & ~flush & ~reset;
      assign m_axis_tvalid = g_stage[DEPTH-1].vld;
      assign m_axis_tdata  = g_stage[DEPTH-1].dat;
      assign m_axis_tlast  = g_stage[DEPTH-1].lst;

      always_comb begin
        nxt_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
          nxt_occ = nxt_occ + OCC_W'(nxt_vld_vec[k]);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          occupancy <= '0;
        end else if (flush) begin
          occupancy <= '0;
        end else begin
          occupancy <= nxt_occ;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axis_delay_line.sv
// Drives DEPTH=3, 4 and 0 delay lines from one shared stream and checks each cycle
// against a beat-position queue model of the delay line.
module tb_axis_delay_line;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        m_axis_tready = 1'b0;

  logic        s_rdy3, m_vld3, m_lst3;
  logic [31:0] m_dat3;
  logic [1:0]  occ3;
  logic        s_rdy4, m_vld4, m_lst4;
  logic [31:0] m_dat4;
  logic [2:0]  occ4;
  logic        s_rdy0, m_vld0, m_lst0;
  logic [31:0] m_dat0;
  logic [0:0]  occ0;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: beats ordered oldest first, each with its stage position.
  int          mdepth[2] = '{3, 4};
  int          mcnt[2];
  int          mpos[2][16];
  logic [32:0] mbeat[2][16];
  logic        madv[2][16];
  logic        mrdy[2];

  logic [31:0] src_dat = 32'hA0;
  logic        src_lst = 1'b0;
  logic        dir_last = 1'b1;

  always #5 clk = ~clk;

  axis_delay_line #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk (clk), .reset (reset), .flush (flush),
    .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_rdy3),
    .s_axis_tdata (s_axis_tdata), .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid (m_vld3), .m_axis_tready (m_axis_tready),
    .m_axis_tdata (m_dat3), .m_axis_tlast (m_lst3), .occupancy (occ3)
  );

  axis_delay_line #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk (clk), .reset (reset), .flush (flush),
    .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_rdy4),
    .s_axis_tdata (s_axis_tdata), .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid (m_vld4), .m_axis_tready (m_axis_tready),
    .m_axis_tdata (m_dat4), .m_axis_tlast (m_lst4), .occupancy (occ4)
  );

  axis_delay_line #(.DATA_WIDTH(32), .DEPTH(0)) u_dut0 (
    .clk (clk), .reset (reset), .flush (flush),
    .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_rdy0),
    .s_axis_tdata (s_axis_tdata), .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid (m_vld0), .m_axis_tready (m_axis_tready),
    .m_axis_tdata (m_dat0), .m_axis_tlast (m_lst0), .occupancy (occ0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A beat moves if the slot ahead is free or its occupant moves; the oldest
  // beat leaves only from the last slot when downstream is ready.
  task automatic model_predict(input int m);
    if (reset) mcnt[m] = 0;
    for (int k = 0; k < mcnt[m]; k++) begin
      if (k == 0)
        madv[m][k] = (mpos[m][0] == mdepth[m] - 1) ? m_axis_tready : 1'b1;
      else if (mpos[m][k] + 1 == mpos[m][k-1])
        madv[m][k] = madv[m][k-1];
      else
        madv[m][k] = 1'b1;
    end
    mrdy[m] = !reset && !flush &&
              (mcnt[m] == 0 || mpos[m][mcnt[m]-1] > 0 || madv[m][mcnt[m]-1]);
  endtask

  task automatic model_update(input int m);
    int n;
    n = 0;
    if (reset || flush) begin
      mcnt[m] = 0;
    end else begin
      for (int k = 0; k < mcnt[m]; k++) begin
        if (!madv[m][k]) begin
          mpos[m][n] = mpos[m][k]; mbeat[m][n] = mbeat[m][k]; n++;
        end else if (mpos[m][k] < mdepth[m] - 1) begin
          mpos[m][n] = mpos[m][k] + 1; mbeat[m][n] = mbeat[m][k]; n++;
        end
      end
      if (s_axis_tvalid && mrdy[m]) begin
        mpos[m][n] = 0; mbeat[m][n] = {s_axis_tlast, s_axis_tdata}; n++;
      end
      mcnt[m] = n;
    end
  endtask

  task automatic model_check(input int m, input logic v, input logic [31:0] d,
                             input logic l, input logic r, input int occ);
    logic ev;
    string p;
    p  = $sformatf("d%0d_", mdepth[m]);
    ev = (mcnt[m] > 0) && (mpos[m][0] == mdepth[m] - 1);
    check({p, "occupancy"}, occ, mcnt[m]);
    check({p, "m_tvalid"}, v, ev);
    check({p, "s_tready"}, r, mrdy[m]);
    if (ev) begin
      check({p, "m_tdata"}, d, mbeat[m][0][31:0]);
      check({p, "m_tlast"}, l, mbeat[m][0][32]);
    end else if (reset) begin
      check({p, "rst_tdata"}, d, 0);
      check({p, "rst_tlast"}, l, 0);
    end
  endtask

  task automatic next_beat();
    src_dat = src_dat + 1;
    src_lst = dir_last ? (src_dat == 32'hA4) : 1'($urandom_range(0, 1));
  endtask

  task automatic step(input logic sv, input logic mr, input logic fl, input logic rs);
    logic acc;
    @(negedge clk);
    s_axis_tvalid = sv;
    m_axis_tready = mr;
    flush         = fl;
    reset         = rs;
    s_axis_tdata  = src_dat;
    s_axis_tlast  = src_lst;
    #1;
    model_predict(0);
    model_predict(1);
    model_check(0, m_vld3, m_dat3, m_lst3, s_rdy3, int'(occ3));
    model_check(1, m_vld4, m_dat4, m_lst4, s_rdy4, int'(occ4));
    check("d0_m_tvalid", m_vld0, sv);
    check("d0_m_tdata", m_dat0, src_dat);
    check("d0_m_tlast", m_lst0, src_lst);
    check("d0_s_tready", s_rdy0, mr);
    check("d0_occupancy", occ0, 0);
    @(posedge clk);
    acc = sv && mrdy[0];
    model_update(0);
    model_update(1);
    if (acc) next_beat();
  endtask

  initial begin
    mcnt[0] = 0;
    mcnt[1] = 0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back A0..A4 with downstream always ready.
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    dir_last = 1'b0;

    // Five offered against a stalled sink, then drain.
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Bubbled input under backpressure.
    for (int i = 0; i < 4; i++) step(i % 2 == 0, 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Fill, then stream through a full pipe.
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Flush with two beats held and input still offered.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset pulse while full.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
